pipe_stall_ctrl: RTL and testbench

Central stall/flush sequencer for the 5-stage pipelined CPU.
- Combines data-memory wait handshakes, load-use hazards and taken branches.
- Drives PC write enable, IF/ID write/flush, the ID/EX bubble-mux select and the global mem_stall freeze that all pipeline registers (IF/ID, ID/EX, EX/MEM, MEM/WB) honour.
- Keeps stall statistics and a memory-timeout watchdog for debug.

---
 rtl/pipe_stall_ctrl_if.sv | 34 +++
 rtl/pipe_stall_ctrl.sv | 141 ++++++++++++++
 tb/tb_pipe_stall_ctrl.sv | 134 +++++++++++++
 3 files changed

// File: rtl/pipe_stall_ctrl_if.sv
// rtl/pipe_stall_ctrl_if.sv - Pipeline stall/flush control bundle between CPU datapath and sequencer.
// master: datapath side (drives hazards/memory handshake); slave: the sequencer.
interface pipe_stall_ctrl_if #(
  parameter int CNT_W = 32
);
  logic             start_i;
  logic             hazard_i;
  logic             branch_i;
  logic             mem_req_i;
  logic             mem_ack_i;

  logic             pc_write_o;
  logic             ifid_write_o;
  logic             ifid_flush_o;
  logic             bubble_o;
  logic             mem_stall_o;
  logic [1:0]       state_o;
  logic             err_o;
  logic [CNT_W-1:0] stall_cnt_o;
  logic [CNT_W-1:0] bubble_cnt_o;
  logic [CNT_W-1:0] flush_cnt_o;

  modport master (
    output start_i, hazard_i, branch_i, mem_req_i, mem_ack_i,
    input  pc_write_o, ifid_write_o, ifid_flush_o, bubble_o, mem_stall_o,
    input  state_o, err_o, stall_cnt_o, bubble_cnt_o, flush_cnt_o
  );

  modport slave (
    input  start_i, hazard_i, branch_i, mem_req_i, mem_ack_i,
    output pc_write_o, ifid_write_o, ifid_flush_o, bubble_o, mem_stall_o,
    output state_o, err_o, stall_cnt_o, bubble_cnt_o, flush_cnt_o
  );
endinterface

// File: rtl/pipe_stall_ctrl.sv
// rtl/pipe_stall_ctrl.sv - Stall/flush sequencer for the 5-stage pipeline with stall statistics and memory watchdog.
// Control outputs are combinational from state and inputs so a memory ack releases the pipeline in the same cycle.
module pipe_stall_ctrl #(
  parameter int TIMEOUT = 64,
  parameter int CNT_W   = 32
) (
  input  logic              clk,
  input  logic              rst,
  pipe_stall_ctrl_if.slave  bus
);

  localparam int WAIT_W = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_RUN      = 2'd1,
    S_MEM_WAIT = 2'd2,
    S_ERROR    = 2'd3
  } state_e;

  state_e              state_q, state_d;
  logic [WAIT_W-1:0]   wait_q, wait_d;
  logic [WAIT_W-1:0]   wait_inc;
  logic                err_q, err_d;
  logic [CNT_W-1:0]    stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0]    bubble_cnt_q, bubble_cnt_d;
  logic [CNT_W-1:0]    flush_cnt_q, flush_cnt_d;

  logic mstall;
  logic active;
  logic pc_write, ifid_write, ifid_flush, bubble, mem_stall;

  assign mstall   = bus.mem_req_i & ~bus.mem_ack_i;
  assign active   = (state_q == S_RUN) || (state_q == S_MEM_WAIT);
  assign wait_inc = wait_q + WAIT_W'(1);

  always_comb begin
    state_d    = state_q;
    wait_d     = wait_q;
    err_d      = err_q;
    pc_write   = 1'b0;
    ifid_write = 1'b0;
    ifid_flush = 1'b0;
    bubble     = 1'b0;
    mem_stall  = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (bus.start_i) begin
          state_d = S_RUN;
        end
      end

      S_RUN, S_MEM_WAIT: begin
        if (mstall) begin
          // Memory freeze dominates; hazard/branch re-present after release.
          mem_stall = 1'b1;
          if (state_q == S_RUN) begin
            state_d = S_MEM_WAIT;
            wait_d  = '0;
          end else begin
            wait_d = wait_inc;
            if (wait_inc >= WAIT_W'(TIMEOUT)) begin
              state_d = S_ERROR;
              err_d   = 1'b1;
            end
          end
        end else begin
          if (state_q == S_MEM_WAIT) begin
            state_d = S_RUN;
          end
          if (bus.hazard_i) begin
            // Branch operands are not valid yet during a load-use stall, so no flush.
            bubble = 1'b1;
          end else if (bus.branch_i) begin
            pc_write   = 1'b1;
            ifid_write = 1'b1;
            ifid_flush = 1'b1;
          end else begin
            pc_write   = 1'b1;
            ifid_write = 1'b1;
          end
        end
      end

      S_ERROR: begin
        mem_stall = 1'b1;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_comb begin
    stall_cnt_d  = stall_cnt_q;
    bubble_cnt_d = bubble_cnt_q;
    flush_cnt_d  = flush_cnt_q;
    // The ERROR-state hold is not a memory stall and is kept out of the statistics.
    if (mem_stall && active) begin
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end
    if (bubble) begin
      bubble_cnt_d = bubble_cnt_q + CNT_W'(1);
    end
    if (ifid_flush) begin
      flush_cnt_d = flush_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      wait_q       <= '0;
      err_q        <= 1'b0;
      stall_cnt_q  <= '0;
      bubble_cnt_q <= '0;
      flush_cnt_q  <= '0;
    end else begin
      state_q      <= state_d;
      wait_q       <= wait_d;
      err_q        <= err_d;
      stall_cnt_q  <= stall_cnt_d;
      bubble_cnt_q <= bubble_cnt_d;
      flush_cnt_q  <= flush_cnt_d;
    end
  end

  assign bus.pc_write_o   = pc_write;
  assign bus.ifid_write_o = ifid_write;
  assign bus.ifid_flush_o = ifid_flush;
  assign bus.bubble_o     = bubble;
  assign bus.mem_stall_o  = mem_stall;
  assign bus.state_o      = state_q;
  assign bus.err_o        = err_q;
  assign bus.stall_cnt_o  = stall_cnt_q;
  assign bus.bubble_cnt_o = bubble_cnt_q;
  assign bus.flush_cnt_o  = flush_cnt_q;

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// tb/tb_pipe_stall_ctrl.sv - Scoreboard bench for pipe_stall_ctrl with directed cycle vectors.
// Stimulus pushes the expected per-cycle response; a negedge monitor pops and compares.
module tb_pipe_stall_ctrl;

  localparam int CNT_W = 32;

  logic clk;
  logic rst;

  pipe_stall_ctrl_if #(.CNT_W(CNT_W)) bus ();

  pipe_stall_ctrl #(.TIMEOUT(4), .CNT_W(CNT_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // outs = {pc_write, ifid_write, ifid_flush, bubble, mem_stall}
  typedef struct {
    string       name;
    logic [1:0]  st;
    logic [4:0]  outs;
    logic        err;
    logic [31:0] sc;
    logic [31:0] bc;
    logic [31:0] fc;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  task automatic cyc(input string name, input bit chk,
                     input logic r, input logic st_i, input logic hz, input logic br,
                     input logic req, input logic ack,
                     input logic [1:0] st, input logic [4:0] outs, input logic err,
                     input int sc, input int bc, input int fc);
    exp_t e;
    @(posedge clk);
    #1;
    rst           = r;
    bus.start_i   = st_i;
    bus.hazard_i  = hz;
    bus.branch_i  = br;
    bus.mem_req_i = req;
    bus.mem_ack_i = ack;
    if (chk) begin
      e.name = name;
      e.st   = st;
      e.outs = outs;
      e.err  = err;
      e.sc   = sc;
      e.bc   = bc;
      e.fc   = fc;
      exp_q.push_back(e);
    end
  endtask

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      logic [4:0] act;
      e   = exp_q.pop_front();
      act = {bus.pc_write_o, bus.ifid_write_o, bus.ifid_flush_o, bus.bubble_o, bus.mem_stall_o};
      checks++;
      if (bus.state_o !== e.st || act !== e.outs || bus.err_o !== e.err ||
          bus.stall_cnt_o !== e.sc || bus.bubble_cnt_o !== e.bc || bus.flush_cnt_o !== e.fc) begin
        errors++;
        $display("FAIL %s: got st=%0d outs=%b err=%b sc=%0d bc=%0d fc=%0d, expected st=%0d outs=%b err=%b sc=%0d bc=%0d fc=%0d",
                 e.name, bus.state_o, act, bus.err_o, bus.stall_cnt_o, bus.bubble_cnt_o, bus.flush_cnt_o,
                 e.st, e.outs, e.err, e.sc, e.bc, e.fc);
      end
    end
  end

  initial begin
    rst = 1'b1;
    bus.start_i = 1'b0; bus.hazard_i = 1'b0; bus.branch_i = 1'b0;
    bus.mem_req_i = 1'b0; bus.mem_ack_i = 1'b0;

    //  name            chk rst st hz br rq ak  st  outs      err sc bc fc
    cyc("rst_a",        0,  1, 0, 0, 0, 0, 0, 0, 5'b00000, 0, 0, 0, 0);
    cyc("rst_b",        1,  1, 0, 0, 0, 0, 0, 0, 5'b00000, 0, 0, 0, 0);
    cyc("start",        1,  0, 1, 0, 0, 0, 0, 0, 5'b00000, 0, 0, 0, 0);
    cyc("run_first",    1,  0, 0, 0, 0, 0, 0, 1, 5'b11000, 0, 0, 0, 0);
    // memory wait: three stalled cycles then ack
    cyc("mw_run",       1,  0, 0, 0, 0, 1, 0, 1, 5'b00001, 0, 0, 0, 0);
    cyc("mw_wait1",     1,  0, 0, 0, 0, 1, 0, 2, 5'b00001, 0, 1, 0, 0);
    cyc("mw_wait2",     1,  0, 0, 0, 0, 1, 0, 2, 5'b00001, 0, 2, 0, 0);
    cyc("mw_ack",       1,  0, 0, 0, 0, 1, 1, 2, 5'b11000, 0, 3, 0, 0);
    cyc("mw_back_run",  1,  0, 0, 0, 0, 0, 0, 1, 5'b11000, 0, 3, 0, 0);
    // load-use bubble
    cyc("hazard",       1,  0, 0, 1, 0, 0, 0, 1, 5'b00010, 0, 3, 0, 0);
    cyc("after_haz",    1,  0, 0, 0, 0, 0, 0, 1, 5'b11000, 0, 3, 1, 0);
    // branch flush and priority
    cyc("branch",       1,  0, 0, 0, 1, 0, 0, 1, 5'b11100, 0, 3, 1, 0);
    cyc("after_br",     1,  0, 0, 0, 0, 0, 0, 1, 5'b11000, 0, 3, 1, 1);
    cyc("haz_br",       1,  0, 0, 1, 1, 0, 0, 1, 5'b00010, 0, 3, 1, 1);
    cyc("ms_haz_br",    1,  0, 0, 1, 1, 1, 0, 1, 5'b00001, 0, 3, 2, 1);
    cyc("rel_noreq",    1,  0, 0, 0, 0, 0, 0, 2, 5'b11000, 0, 4, 2, 1);
    cyc("run_again",    1,  0, 0, 0, 0, 0, 0, 1, 5'b11000, 0, 4, 2, 1);
    cyc("req_ack_start",1,  0, 1, 0, 0, 1, 1, 1, 5'b11000, 0, 4, 2, 1);
    // watchdog timeout with TIMEOUT=4
    cyc("to_run",       1,  0, 0, 0, 0, 1, 0, 1, 5'b00001, 0, 4, 2, 1);
    cyc("to_w1",        1,  0, 0, 0, 0, 1, 0, 2, 5'b00001, 0, 5, 2, 1);
    cyc("to_w2",        1,  0, 0, 0, 0, 1, 0, 2, 5'b00001, 0, 6, 2, 1);
    cyc("to_w3",        1,  0, 0, 0, 0, 1, 0, 2, 5'b00001, 0, 7, 2, 1);
    cyc("to_w4",        1,  0, 0, 0, 0, 1, 0, 2, 5'b00001, 0, 8, 2, 1);
    cyc("err_hold",     1,  0, 0, 0, 0, 1, 0, 3, 5'b00001, 1, 9, 2, 1);
    cyc("err_ignore",   1,  0, 1, 1, 1, 0, 1, 3, 5'b00001, 1, 9, 2, 1);
    cyc("err_rst",      1,  1, 0, 0, 0, 0, 0, 3, 5'b00001, 1, 9, 2, 1);
    cyc("after_rst",    1,  0, 0, 0, 0, 0, 0, 0, 5'b00000, 0, 0, 0, 0);
    // reset in the middle of a memory wait
    cyc("mr_start",     1,  0, 1, 0, 0, 0, 0, 0, 5'b00000, 0, 0, 0, 0);
    cyc("mr_run",       1,  0, 0, 0, 0, 1, 0, 1, 5'b00001, 0, 0, 0, 0);
    cyc("mr_wait",      1,  0, 0, 0, 0, 1, 0, 2, 5'b00001, 0, 1, 0, 0);
    cyc("mr_rst",       1,  1, 0, 0, 0, 1, 0, 2, 5'b00001, 0, 2, 0, 0);
    cyc("mr_late_ack",  1,  0, 0, 0, 0, 1, 1, 0, 5'b00000, 0, 0, 0, 0);
    cyc("mr_idle",      1,  0, 0, 0, 0, 0, 0, 0, 5'b00000, 0, 0, 0, 0);

    repeat (3) @(posedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending entries, expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
